usb_rcv_ctrl: RTL and testbench

Receive control unit for the USB 1.1 full-speed receiver. It sequences the NRZI decode/shift datapath across one packet:
- detects packet start and validates the sync byte;
- counts bits into bytes and issues one write strobe per data byte to the RX FIFO;
- flags malformed packets and returns to idle after EOP.

It sits between the decoder/EOP detector/shift register and the RX FIFO and packet-level logic.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_bit_counter.sv | 28 ++
 rtl/usb_rcv_ctrl.sv | 139 +++++++++++++
 tb/tb_usb_rcv_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

  localparam logic [7:0] USB_SYNC    = 8'h80;
  localparam int         CLK_PER_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SYNC_CHK,
    RCV,
    STORE,
    EOP_WAIT,
    ERR,
    ERR_EOP
  } rcv_state_t;

endpackage

// File: rtl/usb_bit_counter.sv
// 3-bit bit-position counter with synchronous clear (dominant), count enable
// and a terminal-count flag at 7.
module usb_bit_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear_i,
  input  logic       enable_i,
  output logic [2:0] count_o,
  output logic       tc_o
);

  logic [2:0] count_q;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 3'd1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == 3'd7);

endmodule

// File: rtl/usb_rcv_ctrl.sv
// Receive control for the USB 1.1 full-speed receiver: sync check, byte
// framing, one FIFO write strobe per data byte, error flagging and EOP handling.
module usb_rcv_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = USB_SYNC,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             shift_enable,
  input  logic             eop,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  rcv_state_t       state_q;
  logic             rcving_q;
  logic             w_enable_q;
  logic             r_error_q;
  logic [CNT_W-1:0] byte_count_q;

  logic [2:0] bit_cnt;
  logic       bit_tc;
  logic       bit_clr;
  logic       bit_en;
  logic       byte_done;
  logic       eop_hit;

  // Counter restarts whenever SYNC or RCV is (re)entered; extra clears elsewhere are harmless.
  assign bit_clr   = ((state_q == IDLE) && d_edge) || (state_q == SYNC_CHK) || (state_q == STORE);
  assign bit_en    = shift_enable && ((state_q == SYNC) || (state_q == RCV));
  assign eop_hit   = shift_enable && eop;
  assign byte_done = shift_enable && !eop && bit_tc;

  usb_bit_counter u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (bit_clr),
    .enable_i (bit_en),
    .count_o  (bit_cnt),
    .tc_o     (bit_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      rcving_q     <= 1'b0;
      w_enable_q   <= 1'b0;
      r_error_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      w_enable_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_edge) begin
            state_q      <= SYNC;
            rcving_q     <= 1'b1;
            r_error_q    <= 1'b0;
            byte_count_q <= '0;
          end
        end
        SYNC: begin
          if (eop_hit) begin
            state_q   <= ERR;
            r_error_q <= 1'b1;
          end else if (byte_done) begin
            state_q <= SYNC_CHK;
          end
        end
        SYNC_CHK: begin
          if (rcv_data == SYNC_BYTE) begin
            state_q <= RCV;
          end else begin
            state_q   <= ERR;
            r_error_q <= 1'b1;
          end
        end
        RCV: begin
          if (eop_hit) begin
            if ((bit_cnt == 3'd0) && (byte_count_q != '0)) begin
              state_q <= EOP_WAIT;
            end else begin
              state_q   <= ERR;
              r_error_q <= 1'b1;
            end
          end else if (byte_done) begin
            // Strobe is raised while STORE is occupied, unless the packet is already full.
            state_q    <= STORE;
            w_enable_q <= (byte_count_q != MAX_CNT);
          end
        end
        STORE: begin
          if (byte_count_q == MAX_CNT) begin
            state_q   <= ERR;
            r_error_q <= 1'b1;
          end else begin
            state_q      <= RCV;
            byte_count_q <= byte_count_q + CNT_W'(1);
          end
        end
        EOP_WAIT: begin
          if (d_edge) begin
            state_q  <= IDLE;
            rcving_q <= 1'b0;
          end
        end
        ERR: begin
          if (eop_hit) begin
            state_q <= ERR_EOP;
          end
        end
        ERR_EOP: begin
          if (d_edge) begin
            state_q  <= IDLE;
            rcving_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rcving_q <= 1'b0;
        end
      endcase
    end
  end

  assign rcving     = rcving_q;
  assign w_enable   = w_enable_q;
  assign r_error    = r_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Bench for usb_rcv_ctrl: two instances (default and MAX_BYTES=2) share one
// bit-level stimulus stream and are checked against a per-packet outcome model.
module tb_usb_rcv_ctrl;
  import usb_rx_pkg::*;

  localparam int MAX_A = 64;
  localparam int MAX_B = 2;
  localparam int CNT_W = 7;
  localparam int HIST  = 1 << 16;

  typedef struct {
    logic [7:0] sync;
    int         sync_bits;
    int         n_full;
    int         extra;
    bit         fixed_data;
  } pkt_t;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             d_edge;
  logic             shift_enable;
  logic             eop;
  logic [7:0]       rcv_data;
  logic             rcving_a, w_enable_a, r_error_a;
  logic             rcving_b, w_enable_b, r_error_b;
  logic [CNT_W-1:0] byte_count_a, byte_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit rcv_h [0:1][0:HIST-1];
  bit err_h [0:1][0:HIST-1];
  int obs_a[$];
  int obs_b[$];
  int done_cyc[$];
  int start_cyc, sync_cyc, j_cyc, last_se_cyc;

  always #5 clk = ~clk;

  usb_rcv_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAX_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable), .eop(eop),
    .rcv_data(rcv_data), .rcving(rcving_a), .w_enable(w_enable_a), .r_error(r_error_a),
    .byte_count(byte_count_a)
  );

  usb_rcv_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAX_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable), .eop(eop),
    .rcv_data(rcv_data), .rcving(rcving_b), .w_enable(w_enable_b), .r_error(r_error_b),
    .byte_count(byte_count_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder: per-cycle history and the cycle of every write strobe.
  always @(negedge clk) begin
    if (cyc < HIST) begin
      rcv_h[0][cyc] = rcving_a;
      rcv_h[1][cyc] = rcving_b;
      err_h[0][cyc] = r_error_a;
      err_h[1][cyc] = r_error_b;
    end
    if (w_enable_a) obs_a.push_back(cyc);
    if (w_enable_b) obs_b.push_back(cyc);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packet outcome from the protocol rules: valid sync, then whole bytes up to
  // the limit; anything short, partial or over-long is an error.
  function automatic void model(input pkt_t p, input int max_b, output bit err, output int cnt);
    bit sync_ok;
    sync_ok = (p.sync_bits == 8) && (p.sync == 8'h80);
    if (!sync_ok) begin
      err = 1'b1;
      cnt = 0;
    end else begin
      cnt = (p.n_full < max_b) ? p.n_full : max_b;
      err = (p.n_full == 0) || (p.extra != 0) || (p.n_full > max_b);
    end
  endfunction

  task automatic send_bit(input logic b, input logic is_eop, input bit jitter);
    shift_enable = 1'b1;
    eop          = is_eop;
    last_se_cyc  = cyc;
    @(negedge clk);
    shift_enable = 1'b0;
    eop          = 1'b0;
    if (!is_eop) rcv_data = {b, rcv_data[7:1]};
    for (int i = 1; i < CLK_PER_BIT; i++) begin
      if (jitter && i == 4 && $urandom_range(1, 0) == 1) d_edge = 1'b1;
      @(negedge clk);
      d_edge = 1'b0;
    end
  endtask

  task automatic send_packet(input pkt_t p);
    logic [7:0] b;
    done_cyc.delete();
    obs_a.delete();
    obs_b.delete();
    d_edge    = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    d_edge = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < p.sync_bits; i++) send_bit(p.sync[i], 1'b0, 1'b1);
    sync_cyc = last_se_cyc;
    if (p.sync_bits == 8) begin
      for (int k = 0; k < p.n_full; k++) begin
        b = 8'($urandom);
        if (p.fixed_data && k == 0) b = 8'hA5;
        if (p.fixed_data && k == 1) b = 8'h3C;
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b1);
        done_cyc.push_back(last_se_cyc);
      end
      for (int i = 0; i < p.extra; i++) send_bit(1'($urandom_range(1, 0)), 1'b0, 1'b1);
    end
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    d_edge = 1'b1;
    j_cyc  = cyc;
    @(negedge clk);
    d_edge = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b1; d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0; rcv_data = 8'h00;
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [CNT_W+2:0] got;
      got = d ? {rcving_b, w_enable_b, r_error_b, byte_count_b}
              : {rcving_a, w_enable_a, r_error_a, byte_count_a};
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %h expected 0", d, got);
      end
    end
  endtask

  task automatic test_packets();
    pkt_t pkts[$];
    pkt_t p;
    logic [7:0] flip;
    pkts.push_back('{8'h80, 8, 2, 0, 1'b1});   // clean two-byte packet
    pkts.push_back('{8'h80, 8, 1, 4, 1'b1});   // EOP at bit 4 of second byte
    pkts.push_back('{8'h80, 8, 3, 0, 1'b1});   // overflows the small instance
    pkts.push_back('{8'h80, 8, 0, 0, 1'b1});   // sync then EOP
    pkts.push_back('{8'h80, 8, 1, 7, 1'b0});   // EOP on bit 7 beats byte_done
    pkts.push_back('{8'h80, 7, 0, 0, 1'b0});   // EOP inside sync
    pkts.push_back('{8'h80, 8, 65, 0, 1'b0});  // overflows the default instance
    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(9, 0));
      flip = 8'h01;
      flip = flip << $urandom_range(7, 0);
      p.sync       = (r == 0) ? (8'h80 ^ flip) : 8'h80;
      p.sync_bits  = (r == 1) ? int'($urandom_range(7, 0)) : 8;
      p.n_full     = int'($urandom_range(4, 0));
      p.extra      = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      p.fixed_data = 1'b0;
      pkts.push_back(p);
    end
    for (int n = 0; n < pkts.size(); n++) begin
      send_packet(pkts[n]);
      for (int d = 0; d < 2; d++) begin
        int oq[$];
        int cnt, bc;
        bit err;
        logic r_err, rcv;
        model(pkts[n], d ? MAX_B : MAX_A, err, cnt);
        oq    = d ? obs_b : obs_a;
        r_err = d ? r_error_b : r_error_a;
        rcv   = d ? rcving_b : rcving_a;
        bc    = d ? int'(byte_count_b) : int'(byte_count_a);
        n_cmp++;
        if (oq.size() != cnt) begin
          n_bad++;
          $display("FAIL pkt%0d dut%0d wen_count: got %0d expected %0d", n, d, oq.size(), cnt);
        end
        for (int k = 0; k < cnt && k < oq.size(); k++) begin
          n_cmp++;
          if (oq[k] != done_cyc[k] + 1) begin
            n_bad++;
            $display("FAIL pkt%0d dut%0d wen_cycle[%0d]: got %0d expected %0d",
                     n, d, k, oq[k], done_cyc[k] + 1);
          end
        end
        n_cmp++;
        if (r_err !== err) begin
          n_bad++;
          $display("FAIL pkt%0d dut%0d r_error: got %b expected %b", n, d, r_err, err);
        end
        n_cmp++;
        if (bc != cnt) begin
          n_bad++;
          $display("FAIL pkt%0d dut%0d byte_count: got %0d expected %0d", n, d, bc, cnt);
        end
        n_cmp++;
        if (rcv_h[d][j_cyc] !== 1'b1 || rcv_h[d][j_cyc + 1] !== 1'b0 || rcv !== 1'b0) begin
          n_bad++;
          $display("FAIL pkt%0d dut%0d rcving_fall: got %b%b%b expected 100", n, d,
                   rcv_h[d][j_cyc], rcv_h[d][j_cyc + 1], rcv);
        end
        n_cmp++;
        if (err_h[d][start_cyc + 1] !== 1'b0) begin
          n_bad++;
          $display("FAIL pkt%0d dut%0d r_error_clear_at_start: got 1 expected 0", n, d);
        end
      end
    end
  endtask

  task automatic test_bad_sync();
    send_packet('{8'h81, 8, 1, 0, 1'b0});
    for (int d = 0; d < 2; d++) begin
      int oq[$];
      oq = d ? obs_b : obs_a;
      n_cmp++;
      if (err_h[d][sync_cyc + 1] !== 1'b0 || err_h[d][sync_cyc + 2] !== 1'b1) begin
        n_bad++;
        $display("FAIL bad_sync dut%0d r_error_timing: got %b%b expected 01", d,
                 err_h[d][sync_cyc + 1], err_h[d][sync_cyc + 2]);
      end
      n_cmp++;
      if (oq.size() != 0) begin
        n_bad++;
        $display("FAIL bad_sync dut%0d wen_count: got %0d expected 0", d, oq.size());
      end
      n_cmp++;
      if ((d ? {r_error_b, rcving_b} : {r_error_a, rcving_a}) !== 2'b10) begin
        n_bad++;
        $display("FAIL bad_sync dut%0d idle_flags: got %b%b expected 10", d,
                 d ? r_error_b : r_error_a, d ? rcving_b : rcving_a);
      end
    end
    send_packet('{8'h80, 8, 1, 0, 1'b0});
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (err_h[d][start_cyc] !== 1'b1 || err_h[d][start_cyc + 1] !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_sync dut%0d r_error_clear: got %b%b expected 10", d,
                 err_h[d][start_cyc], err_h[d][start_cyc + 1]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    obs_a.delete();
    obs_b.delete();
    d_edge = 1'b1;
    @(negedge clk);
    d_edge = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(i == 7, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({rcving_a, w_enable_a, r_error_a, byte_count_a, rcving_b, w_enable_b, r_error_b, byte_count_b} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset async_clear: got a=%b%b%b/%0d b=%b%b%b/%0d expected all 0",
               rcving_a, w_enable_a, r_error_a, byte_count_a, rcving_b, w_enable_b, r_error_b, byte_count_b);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (obs_a.size() != 1 || obs_b.size() != 1) begin
      n_bad++;
      $display("FAIL mid_reset wen_count: got %0d/%0d expected 1/1", obs_a.size(), obs_b.size());
    end
    send_packet('{8'h80, 8, 2, 0, 1'b1});
    n_cmp++;
    if (obs_a.size() != 2 || obs_a[0] != done_cyc[0] + 1 || obs_a[1] != done_cyc[1] + 1) begin
      n_bad++;
      $display("FAIL post_reset wen_a: got %0d strobes expected 2 at %0d,%0d",
               obs_a.size(), done_cyc[0] + 1, done_cyc[1] + 1);
    end
    n_cmp++;
    if ({r_error_a, byte_count_a, r_error_b, byte_count_b} !== {1'b0, 7'd2, 1'b0, 7'd2}) begin
      n_bad++;
      $display("FAIL post_reset result: got a=%b/%0d b=%b/%0d expected 0/2 0/2",
               r_error_a, byte_count_a, r_error_b, byte_count_b);
    end
  endtask

  initial begin
    test_reset();
    test_packets();
    test_bad_sync();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
